// File: rtl/decoder_seq_nx.sv
// ---------------------------------------------------------------------------
// decoder_seq_nx
//
// Registered one-hot decoder with sequencing. SEL_W-bit indices drive OUT_N
// one-hot outputs in one of two modes:
//   - direct : a loaded index is latched and decoded
//   - scan   : the index steps round-robin, one step every div+1 cycles
//
// Optional feature macro: DECODER_ERR_EN
//   When defined, adds a sticky 'err' output that is raised by an
//   out-of-range load in direct mode and cleared by reset or a return to
//   IDLE. When undefined, the port does not exist and out-of-range loads
//   only blank the output.
//
// All outputs come straight from flops. The reset is asynchronous and
// active-high, so outputs clear as soon as rst rises.
// ---------------------------------------------------------------------------
module decoder_seq_nx #(
    parameter int SEL_W = 4,
    parameter int OUT_N = 16,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic [OUT_N-1:0] dout,
    output logic [SEL_W-1:0] idx,
    output logic             valid,
    output logic             wrap
`ifdef DECODER_ERR_EN
    ,
    output logic             err
`endif
);

    // -----------------------------------------------------------------------
    // Types and constants
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // OUT_N held one bit wider than an index so OUT_N == 2^SEL_W still fits
    localparam logic [SEL_W:0]   LP_OUT_N   = (SEL_W+1)'(OUT_N);
    // Highest legal index; the scan wraps back to zero after it
    localparam logic [SEL_W-1:0] LP_LAST    = SEL_W'(OUT_N - 1);
    localparam logic [SEL_W-1:0] LP_IDX_0   = SEL_W'(0);
    localparam logic [SEL_W-1:0] LP_IDX_1   = SEL_W'(1);
    localparam logic [DIV_W-1:0] LP_PRE_0   = DIV_W'(0);
    localparam logic [DIV_W-1:0] LP_PRE_1   = DIV_W'(1);
    localparam logic [OUT_N-1:0] LP_DOUT_0  = OUT_N'(0);

    // -----------------------------------------------------------------------
    // Helper: one-hot decode of an index. An index at or above OUT_N shifts
    // the single set bit out of range and yields all-zero, which is also
    // the safe value for a blanked output.
    // -----------------------------------------------------------------------
    function automatic logic [OUT_N-1:0] f_onehot(input logic [SEL_W-1:0] i_val);
        logic [OUT_N-1:0] v_one;
        v_one = OUT_N'(1);
        return v_one << i_val;
    endfunction

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t           r_state;
    logic [OUT_N-1:0] r_dout;
    logic [SEL_W-1:0] r_idx;
    logic             r_valid;
    logic             r_wrap;
    logic [DIV_W-1:0] r_pre;

    // -----------------------------------------------------------------------
    // Combinational next values
    // -----------------------------------------------------------------------
    state_t           w_state_nxt;
    logic [OUT_N-1:0] w_dout_nxt;
    logic [SEL_W-1:0] w_idx_nxt;
    logic             w_valid_nxt;
    logic             w_wrap_nxt;
    logic [DIV_W-1:0] w_pre_nxt;

    logic             w_entry;     // the coming edge changes state
    logic             w_sel_ok;    // sel addresses an existing output
    logic             w_step;      // prescaler has reached the step period
    logic [SEL_W-1:0] w_idx_adv;   // index after one round-robin advance

    // -----------------------------------------------------------------------
    // FSM: next state is purely a function of en/mode; en low always wins
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = ST_IDLE;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else if (mode) begin
            w_state_nxt = ST_SCAN;
        end else begin
            w_state_nxt = ST_DIRECT;
        end
    end

    // Helpers: entry detection, range check and the scan advance value
    always_comb begin
        w_entry  = (w_state_nxt != r_state);
        w_sel_ok = ({1'b0, sel} < LP_OUT_N);
        // div is sampled at every compare; a lowered div below the running
        // prescaler value is only matched after the prescaler rolls over
        w_step   = (r_pre == div);
        if (r_idx == LP_LAST) begin
            w_idx_adv = LP_IDX_0;
        end else begin
            w_idx_adv = r_idx + LP_IDX_1;
        end
    end

    // Datapath next values, selected by the state being entered or held
    always_comb begin
        w_dout_nxt  = r_dout;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_wrap_nxt  = 1'b0;
        w_pre_nxt   = LP_PRE_0;
        case (w_state_nxt)
            ST_IDLE: begin
                w_dout_nxt  = LP_DOUT_0;
                w_idx_nxt   = LP_IDX_0;
                w_valid_nxt = 1'b0;
            end
            ST_DIRECT: begin
                // Arriving from another state the output stays blank until
                // a load; a load on the entry edge is taken immediately
                if (w_entry) begin
                    w_dout_nxt  = LP_DOUT_0;
                    w_valid_nxt = 1'b0;
                end else begin
                    w_dout_nxt  = r_dout;
                    w_valid_nxt = r_valid;
                end
                if (load) begin
                    if (w_sel_ok) begin
                        w_idx_nxt   = sel;
                        w_dout_nxt  = f_onehot(sel);
                        w_valid_nxt = 1'b1;
                    end else begin
                        // Out of range: blank, keep the last good index
                        w_dout_nxt  = LP_DOUT_0;
                        w_valid_nxt = 1'b0;
                    end
                end else begin
                    w_idx_nxt = r_idx;
                end
            end
            ST_SCAN: begin
                if (w_entry) begin
                    // Any mid-period state from before is discarded
                    w_idx_nxt   = LP_IDX_0;
                    w_dout_nxt  = f_onehot(LP_IDX_0);
                    w_valid_nxt = 1'b1;
                    w_pre_nxt   = LP_PRE_0;
                    w_wrap_nxt  = 1'b0;
                end else if (w_step) begin
                    w_idx_nxt   = w_idx_adv;
                    w_dout_nxt  = f_onehot(w_idx_adv);
                    w_valid_nxt = 1'b1;
                    w_pre_nxt   = LP_PRE_0;
                    // Pulse only when an advance lands on zero
                    w_wrap_nxt  = (w_idx_adv == LP_IDX_0);
                end else begin
                    w_pre_nxt   = r_pre + LP_PRE_1;
                    w_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_dout_nxt  = LP_DOUT_0;
                w_idx_nxt   = LP_IDX_0;
                w_valid_nxt = 1'b0;
                w_wrap_nxt  = 1'b0;
                w_pre_nxt   = LP_PRE_0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output and prescaler registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout  <= LP_DOUT_0;
            r_idx   <= LP_IDX_0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_pre   <= LP_PRE_0;
        end else begin
            r_dout  <= w_dout_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_wrap  <= w_wrap_nxt;
            r_pre   <= w_pre_nxt;
        end
    end

`ifdef DECODER_ERR_EN
    // -----------------------------------------------------------------------
    // Sticky out-of-range flag
    // -----------------------------------------------------------------------
    logic r_err;
    logic w_err_nxt;

    // Set on a taken out-of-range load, cleared only by going to IDLE
    always_comb begin
        w_err_nxt = r_err;
        if (w_state_nxt == ST_IDLE) begin
            w_err_nxt = 1'b0;
        end else if ((w_state_nxt == ST_DIRECT) && load && !w_sel_ok) begin
            w_err_nxt = 1'b1;
        end else begin
            w_err_nxt = r_err;
        end
    end

    // Error flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign err = r_err;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign dout  = r_dout;
    assign idx   = r_idx;
    assign valid = r_valid;
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_decoder_seq_nx.sv
// ---------------------------------------------------------------------------
// tb_decoder_seq_nx
//
// Self-checking bench for decoder_seq_nx with OUT_N=12, SEL_W=4, DIV_W=4
// (OUT_N below 2^SEL_W so out-of-range indices exist; a narrow prescaler so
// rollover after lowering div is reached quickly). A behavioural model
// tracks the expected outputs from the mode rules using plain integers.
// ---------------------------------------------------------------------------
module tb_decoder_seq_nx;

    localparam int SEL_W = 4;
    localparam int OUT_N = 12;
    localparam int DIV_W = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic             load;
    logic [DIV_W-1:0] div;
    logic [OUT_N-1:0] dout;
    logic [SEL_W-1:0] idx;
    logic             valid;
    logic             wrap;
`ifdef DECODER_ERR_EN
    logic             err;
`endif

    decoder_seq_nx #(
        .SEL_W (SEL_W),
        .OUT_N (OUT_N),
        .DIV_W (DIV_W)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .load  (load),
        .div   (div),
        .dout  (dout),
        .idx   (idx),
        .valid (valid),
        .wrap  (wrap)
`ifdef DECODER_ERR_EN
        ,
        .err   (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Model state: 0 = idle, 1 = direct, 2 = scan
    int m_st    = 0;
    int m_idx   = 0;
    int m_pre   = 0;
    bit m_valid = 1'b0;
    bit m_wrap  = 1'b0;
    bit m_err   = 1'b0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [OUT_N-1:0] exp_dout();
        logic [OUT_N-1:0] v;
        v = OUT_N'(0);
        if (m_valid) v = OUT_N'(1) << m_idx;
        return v;
    endfunction

    task automatic m_reset();
        m_st = 0; m_idx = 0; m_pre = 0;
        m_valid = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
    endtask

    // Advance the model by one clock edge using the current inputs
    task automatic m_update();
        if (!en) begin
            m_reset();
        end else if (!mode) begin
            m_wrap = 1'b0;
            m_pre  = 0;
            if (m_st != 1) m_valid = 1'b0;
            m_st = 1;
            if (load) begin
                if (int'(sel) < OUT_N) begin
                    m_idx = int'(sel);
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                    m_err = 1'b1;
                end
            end
        end else if (m_st != 2) begin
            m_st = 2; m_idx = 0; m_valid = 1'b1; m_pre = 0; m_wrap = 1'b0;
        end else if (m_pre == int'(div)) begin
            m_pre  = 0;
            m_idx  = (m_idx + 1) % OUT_N;
            m_wrap = (m_idx == 0);
        end else begin
            m_pre  = (m_pre + 1) % (1 << DIV_W);
            m_wrap = 1'b0;
        end
    endtask

    task automatic cmp_all();
        chk_val("dout",   32'(dout),  32'(exp_dout()));
        chk_val("idx",    32'(idx),   32'(m_idx));
        chk_val("valid",  32'(valid), 32'(m_valid));
        chk_val("wrap",   32'(wrap),  32'(m_wrap));
        chk_val("onehot", 32'($countones(dout) <= 1), 32'(1));
`ifdef DECODER_ERR_EN
        chk_val("err",    32'(err),   32'(m_err));
`endif
    endtask

    // One clock: model follows the sampled inputs, outputs checked #1 later
    task automatic tick();
        if (rst) m_reset(); else m_update();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic chk_zero(input string tag);
        chk_val({tag, "_dout"},  32'(dout),  32'(0));
        chk_val({tag, "_idx"},   32'(idx),   32'(0));
        chk_val({tag, "_valid"}, 32'(valid), 32'(0));
        chk_val({tag, "_wrap"},  32'(wrap),  32'(0));
    endtask

    int first_wrap;
    int n_wrap;

    initial begin
        rst = 1'b0; en = 1'b0; mode = 1'b0; sel = 4'd0; load = 1'b0; div = 4'd0;
        #2 rst = 1'b1;
        #1 chk_zero("rst_init");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Direct decode, then hold while load is low
        en = 1'b1; mode = 1'b0; load = 1'b1; sel = 4'd5;
        tick();
        chk_val("dir5_dout",  32'(dout),  32'h020);
        chk_val("dir5_idx",   32'(idx),   32'd5);
        chk_val("dir5_valid", 32'(valid), 32'd1);
        load = 1'b0; sel = 4'd9;
        tick();
        tick();
        chk_val("hold_dout", 32'(dout), 32'h020);

        // Out-of-range load blanks the output and keeps the index
        load = 1'b1; sel = 4'd13;
        tick();
        load = 1'b0;
        chk_val("oor_dout",  32'(dout),  32'h000);
        chk_val("oor_valid", 32'(valid), 32'd0);
        chk_val("oor_idx",   32'(idx),   32'd5);
        tick();

        // Scan with div=2: first wrap exactly OUT_N*3 edges after entry
        mode = 1'b1; div = 4'd2;
        tick();
        chk_val("scan_entry_dout", 32'(dout), 32'h001);
        first_wrap = -1; n_wrap = 0;
        for (int k = 1; k <= OUT_N * 3; k++) begin
            tick();
            if (wrap) begin
                n_wrap++;
                if (first_wrap < 0) first_wrap = k;
            end
        end
        chk_val("scan_first_wrap", 32'(first_wrap), 32'(OUT_N * 3));
        chk_val("scan_wrap_cnt",   32'(n_wrap),     32'd1);

        // div=0: advance every cycle, wrap every OUT_N cycles
        en = 1'b0;
        tick();
        en = 1'b1; div = 4'd0;
        tick();
        n_wrap = 0;
        for (int k = 0; k < 2 * OUT_N; k++) begin
            tick();
            if (wrap) n_wrap++;
        end
        chk_val("div0_wrap_cnt", 32'(n_wrap), 32'd2);

        // Mode switch from mid-period scan at idx=2
        en = 1'b0;
        tick();
        en = 1'b1; mode = 1'b1; div = 4'd3;
        tick();
        for (int k = 0; k < 9; k++) tick();
        chk_val("mid_idx", 32'(idx), 32'd2);
        mode = 1'b0; load = 1'b1; sel = 4'd7;
        tick();
        load = 1'b0;
        chk_val("sw_dout",  32'(dout),  32'h080);
        chk_val("sw_valid", 32'(valid), 32'd1);
        chk_val("sw_wrap",  32'(wrap),  32'd0);
        mode = 1'b1;
        tick();
        chk_val("sw_back_idx",  32'(idx),  32'd0);
        chk_val("sw_back_dout", 32'(dout), 32'h001);

        // Lowering div below the running prescaler value
        div = 4'd6;
        for (int k = 0; k < 5; k++) tick();
        div = 4'd1;
        for (int k = 0; k < 25; k++) tick();

        // Reset mid-scan clears outputs before any edge
        rst = 1'b1;
        #1 chk_zero("rst_mid");
        tick();
        rst = 1'b0;
        tick();

        // Randomised phase
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 99) == 0) rst = 1'b1; else rst = 1'b0;
            en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            load = ($urandom_range(0, 3) == 0);
            sel  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) div = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 29) == 0) div = 4'($urandom_range(0, 2));
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/decoder_seq_nx.md
# decoder_seq_nx

Parametrised, registered one-hot decoder with sequencing. It generalises the fixed 4-to-16 enable-cascaded decoder to SEL_W-bit indices driving OUT_N outputs. It adds two modes: direct (latched index decode) and scan (round-robin stepping with a programmable step period). It sits between control logic and banked resources such as register-file write strobes, display digit drivers and round-robin unit selects.

## Interface
- SEL_W, 4, index width; legal range 1..8
- OUT_N, 16, number of one-hot outputs; 2 ≤ OUT_N ≤ 2^SEL_W
- DIV_W, 8, width of the scan step-period field
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset; one clock domain
- en  in  1  global enable; 0 forces IDLE
- mode  in  1  0 = direct, 1 = scan; sampled while en=1
- sel  in  SEL_W  index to decode in direct mode
- load  in  1  capture sel in direct mode; ignored in scan
- div  in  DIV_W  scan step period minus one, in clk cycles
- dout  out  OUT_N  registered one-hot output; all-zero when not valid
- idx  out  SEL_W  currently decoded index
- valid  out  1  dout holds a decoded index
- wrap  out  1  one-cycle pulse when scan returns from OUT_N-1 to 0

## Operation
- States: IDLE, DIRECT, SCAN. Next state is evaluated each edge:
  - en=0 → IDLE.
  - en=1 and mode=0 → DIRECT.
  - en=1 and mode=1 → SCAN.
- IDLE: dout=0, idx=0, valid=0, wrap=0, prescaler=0.
- Entering DIRECT from another state: dout=0 and valid=0 until the first load. If load=1 on the entry edge, sel is captured on that same edge.
- DIRECT, load=1:
  - If sel < OUT_N: idx←sel, dout←1<<sel, valid←1.
  - Otherwise (out of range): dout←0, valid←0, idx unchanged.
- DIRECT, load=0: all outputs hold.
- Entering SCAN from another state: idx←0, dout←1, valid←1, prescaler←0, wrap←0.
- SCAN stepping:
  - Prescaler increments every cycle. When prescaler == div, it clears to 0 and idx advances.
  - Advance rule: idx←(idx==OUT_N-1) ? 0 : idx+1, with dout←onehot(new idx).
  - wrap=1 on exactly the cycle the registered idx becomes 0 by advance; never on entry.
- div=0: idx advances every cycle.
- div is sampled at each compare. If div is lowered below the current prescaler value, the prescaler runs on and wraps through 2^DIV_W before matching. This is accepted behaviour.
- Mode change while en=1: switch occurs on the next edge, with entry actions as above. A mid-period scan state is discarded.
- Invariant: dout always has at most one bit set, and equals onehot(idx) whenever valid=1.

## Timing
- All outputs are registered. Latency from a sampled load/mode/en to dout is 1 clk edge.
- Reset asserted at any time, including mid-scan, clears every output to 0 immediately. Release is synchronous to the next edge; the block is in IDLE after reset.
- Scan period per output is div+1 cycles. Full rotation is OUT_N·(div+1) cycles.
- wrap is high for exactly 1 cycle per rotation, and is low whenever en=0.

## Configuration
- DECODER_ERR_EN defined:
  - Adds output port err (1 bit), a sticky flag.
  - err is set on the edge an out-of-range load is taken in DIRECT.
  - err is cleared by rst or by entry into IDLE. Entering SCAN does not clear it.
- DECODER_ERR_EN undefined:
  - Port err is absent.
  - Out-of-range loads still produce dout=0, valid=0, with no other indication.

## Test plan
- Reset: rst=1 during an active scan (OUT_N=16, div=3) → dout=0, idx=0, valid=0, wrap=0 immediately, before any clk edge.
- Direct decode: en=1, mode=0, load=1, sel=5 → after 1 edge, dout=16'h0020, idx=5, valid=1. Then load=0, sel=9 → outputs hold.
- Out of range: OUT_N=12, SEL_W=4, load with sel=13 → dout=0, valid=0, idx retains prior value. With DECODER_ERR_EN, err=1 until en=0.
- Scan wrap: OUT_N=4, div=2, mode=1 → idx sequence 0,1,2,3,0 with each value held 3 cycles. wrap=1 only on the single cycle idx first returns to 0, i.e. 12 cycles after entry.
- div=0 scan: OUT_N=16 → idx increments every cycle and wrap pulses every 16 cycles.
- Mode switch: scan at idx=2 mid-period, set mode=0 with load=1, sel=7 on the same edge → dout=16'h0080, valid=1, wrap=0. Switch back to mode=1 → idx=0, dout=16'h0001.
